interrupt_request_register: RTL and testbench

Clocked interrupt request register for the 8259A-compatible PIC. It samples the eight asynchronous IR pins and applies edge or level triggering (LTIM). It holds the pending-request vector that the priority resolver masks and ranks. On the first acknowledge it clears the bit the resolver selected, freezes the vector until the second acknowledge, and flags spurious acknowledges.

---
 rtl/interrupt_request_register.sv | 121 ++++++++++++
 tb/tb_interrupt_request_register.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_request_register.sv
// interrupt_request_register: 8259A-style IRR with IR synchronizers, edge/level
// triggering, acknowledge clear with freeze until INTA_2, and spurious detection.
`default_nettype none

module interrupt_request_register #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] ir_i,
  input  logic       ltim_i,
  input  logic       icw1_write_i,
  input  logic       inta1_i,
  input  logic       inta2_i,
  input  logic [7:0] isr_irr_i,
  output logic [7:0] irr_o,
  output logic       spurious_o
);

  localparam int CNT_MAX = SYNC_STAGES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    FROZEN = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [CNT_W-1:0]            cnt_q;
  logic [7:0]                  armed_q, armed_d;
  logic [7:0]                  latch_q, latch_d;
  logic [7:0]                  irr_q, irr_d;
  logic                        spurious_q, spurious_d;
  state_e                      state_q, state_d;

  logic [7:0] ir_s;
  logic       settled;
  logic       ack;
  logic [7:0] hit;
  logic [7:0] req;

  assign ir_s    = sync_q[SYNC_STAGES-1];
  assign settled = (cnt_q == CNT_W'(CNT_MAX));
  assign ack     = inta1_i && (state_q == IDLE);
  assign hit     = isr_irr_i & irr_q;

  always_comb begin
    armed_d    = armed_q;
    latch_d    = latch_q;
    irr_d      = irr_q;
    state_d    = state_q;
    spurious_d = 1'b0;
    req        = 8'h00;

    // Arming is held off until the synchronizers have flushed their reset zeros.
    armed_d = ~ir_s & (armed_q | {8{settled}});
    latch_d = ir_s & (latch_q | armed_q);
    if (ack) begin
      latch_d = latch_d & ~hit;
    end
    req = ltim_i ? ir_s : latch_d;

    case (state_q)
      IDLE: begin
        if (inta1_i) begin
          irr_d      = req & ~hit;
          spurious_d = (hit == 8'h00);
          state_d    = FROZEN;
        end else begin
          irr_d = req;
        end
      end
      FROZEN: begin
        if (inta2_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!settled) begin
      irr_d = 8'h00;
    end

    if (icw1_write_i) begin
      armed_d    = 8'h00;
      latch_d    = 8'h00;
      irr_d      = 8'h00;
      state_d    = IDLE;
      spurious_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      armed_q    <= 8'h00;
      latch_q    <= 8'h00;
      irr_q      <= 8'h00;
      spurious_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], ir_i};
      if (!settled) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      armed_q    <= armed_d;
      latch_q    <= latch_d;
      irr_q      <= irr_d;
      spurious_q <= spurious_d;
      state_q    <= state_d;
    end
  end

  assign irr_o      = irr_q;
  assign spurious_o = spurious_q;

endmodule

`default_nettype wire

// File: tb/tb_interrupt_request_register.sv
// tb_interrupt_request_register: directed scenarios plus random traffic, checked
// every cycle against a behavioural model of the request register.
`default_nettype none

module tb_interrupt_request_register;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] ir = 8'hFF;
  logic       ltim = 1'b0;
  logic       icw1 = 1'b0;
  logic       inta1 = 1'b0;
  logic       inta2 = 1'b0;
  logic [7:0] isr = 8'h00;
  logic [7:0] irr;
  logic       spurious;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  interrupt_request_register #(.SYNC_STAGES(SYNC)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ir_i         (ir),
    .ltim_i       (ltim),
    .icw1_write_i (icw1),
    .inta1_i      (inta1),
    .inta2_i      (inta2),
    .isr_irr_i    (isr),
    .irr_o        (irr),
    .spurious_o   (spurious)
  );

  // Model: the pins seen through a delay line; a line is "pending" in edge mode
  // once it has been observed low (after settling) and then high.
  logic [7:0] m_hist [SYNC];
  int         m_age;
  bit         m_low_seen [8];
  bit         m_pend [8];
  logic [7:0] m_irr;
  bit         m_frozen;
  bit         m_spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = 8'h00;
      for (int b = 0; b < 8; b++) begin
        m_low_seen[b] = 0;
        m_pend[b]     = 0;
      end
      m_age = 0; m_irr = 8'h00; m_frozen = 0; m_spur = 0;
    end else begin
      logic [7:0] seen;
      logic [7:0] taken;
      logic [7:0] want;
      bit         ready;
      seen  = m_hist[SYNC-1];
      ready = (m_age > SYNC);
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ir;
      if (m_age <= SYNC) m_age = m_age + 1;
      m_spur = 0;
      if (icw1) begin
        for (int b = 0; b < 8; b++) begin
          m_low_seen[b] = 0;
          m_pend[b]     = 0;
        end
        m_irr = 8'h00; m_frozen = 0;
      end else begin
        for (int b = 0; b < 8; b++) begin
          if (seen[b] == 1'b0) begin
            m_pend[b] = 0;
            if (ready) m_low_seen[b] = 1;
          end else if (m_low_seen[b]) begin
            m_pend[b]     = 1;
            m_low_seen[b] = 0;
          end
        end
        taken = 8'h00;
        if (!m_frozen) begin
          if (inta1) begin
            taken    = isr & m_irr;
            m_spur   = (taken == 8'h00);
            m_frozen = 1;
            for (int b = 0; b < 8; b++) if (taken[b]) m_pend[b] = 0;
          end
          for (int b = 0; b < 8; b++) want[b] = ltim ? seen[b] : m_pend[b];
          m_irr = want & ~taken;
        end else if (inta2) begin
          m_frozen = 0;
        end
        if (!ready) m_irr = 8'h00;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      n_chk = n_chk + 1;
      if (irr !== m_irr) begin
        n_fail = n_fail + 1;
        $display("FAIL model_irr t=%0t got %02h expected %02h", $time, irr, m_irr);
      end
      n_chk = n_chk + 1;
      if (spurious !== m_spur) begin
        n_fail = n_fail + 1;
        $display("FAIL model_spurious t=%0t got %0b expected %0b", $time, spurious, m_spur);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s t=%0t got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("reset_irr", irr, 8'h00);
    check("reset_spurious", {7'd0, spurious}, 8'h00);
    cmp_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(20);
    check("held_high_after_reset", irr, 8'h00);
    ir[3] = 1'b0;
    tick(3);
    ir[3] = 1'b1;
    tick(2);
    check("ir3_rise_early", irr, 8'h00);
    tick(1);
    check("ir3_rise", irr, 8'h08);

    // Pulse on IR[5]: set then withdrawn.
    ir[5] = 1'b0;
    tick(3);
    ir[5] = 1'b1;
    tick(3);
    check("ir5_set", irr, 8'h28);
    ir[5] = 1'b0;
    tick(3);
    check("ir5_withdrawn", irr, 8'h08);

    // Acknowledge, freeze, release.
    icw1 = 1'b1; ir = 8'h00;
    tick(1);
    icw1 = 1'b0;
    tick(4);
    ir = 8'h30;
    tick(3);
    check("irr_30", irr, 8'h30);
    inta1 = 1'b1; isr = 8'h10;
    tick(1);
    check("ack_clear", irr, 8'h20);
    inta1 = 1'b0; isr = 8'h00; ir = 8'hB0;
    tick(5);
    check("frozen_hold", irr, 8'h20);
    inta2 = 1'b1;
    tick(1);
    check("release_edge", irr, 8'h20);
    inta2 = 1'b0;
    tick(1);
    check("release_update", irr, 8'hA0);

    // Level mode acknowledge.
    icw1 = 1'b1; ltim = 1'b1; ir = 8'h04;
    tick(1);
    icw1 = 1'b0;
    tick(3);
    check("level_irr", irr, 8'h04);
    inta1 = 1'b1; isr = 8'h04;
    tick(1);
    inta1 = 1'b0; isr = 8'h00;
    check("level_ack", irr, 8'h00);
    tick(3);
    check("level_frozen", irr, 8'h00);
    inta2 = 1'b1;
    tick(1);
    inta2 = 1'b0;
    check("level_release_edge", irr, 8'h00);
    tick(1);
    check("level_reappear", irr, 8'h04);

    // Spurious acknowledge, then reset while frozen.
    ir = 8'h01;
    tick(3);
    check("irr_01", irr, 8'h01);
    inta1 = 1'b1; isr = 8'h80;
    tick(1);
    inta1 = 1'b0; isr = 8'h00;
    check("spurious_pulse", {7'd0, spurious}, 8'h01);
    check("spurious_irr", irr, 8'h01);
    ir = 8'h03;
    tick(1);
    check("spurious_end", {7'd0, spurious}, 8'h00);
    tick(3);
    check("spurious_frozen", irr, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", irr, 8'h00);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    check("after_reset_idle", irr, 8'h03);

    // ICW1 beats INTA_1.
    icw1 = 1'b1; ltim = 1'b0; ir = 8'h00;
    tick(1);
    icw1 = 1'b0;
    tick(4);
    ir = 8'hFF;
    tick(3);
    check("edge_all", irr, 8'hFF);
    icw1 = 1'b1; inta1 = 1'b1; isr = 8'h01;
    tick(1);
    icw1 = 1'b0; inta1 = 1'b0; isr = 8'h00;
    check("icw1_clear", irr, 8'h00);
    check("icw1_no_spurious", {7'd0, spurious}, 8'h00);
    tick(5);
    check("icw1_needs_edge", irr, 8'h00);
    ir = 8'h00;
    tick(3);
    ir = 8'hFF;
    tick(3);
    check("icw1_rearm", irr, 8'hFF);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] flip;
      flip = 8'h00;
      for (int b = 0; b < 8; b++) if ($urandom_range(5) == 0) flip[b] = 1'b1;
      ir = ir ^ flip;
      icw1 = ($urandom_range(99) == 0);
      if (icw1) ltim = $urandom_range(1);
      inta1 = ($urandom_range(7) == 0);
      inta2 = ($urandom_range(5) == 0);
      if (m_irr != 8'h00 && $urandom_range(3) != 0) begin
        int pick;
        pick = $urandom_range(7);
        while (m_irr[pick] == 1'b0) pick = (pick + 1) % 8;
        isr = 8'h01 << pick;
      end else begin
        isr = 8'h01 << $urandom_range(7);
      end
      tick(1);
    end
    icw1 = 1'b0; inta1 = 1'b0; inta2 = 1'b0; isr = 8'h00;
    tick(2);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
